// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory with a fixed access latency.
// Accepts one MemRead/MemWrite request at a time. It answers each request
// with a single-cycle MemReady pulse, and it flags illegal accesses on AddrError.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              AddrError
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req_valid;
  logic              req_illegal;
  logic [IDX_W-1:0]  req_idx;
  logic              enter_resp;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic              c_rd, c_wr, c_illegal;
  logic              mem_we;

  // Decode the incoming request: word index and legality.
  always_comb begin
    req_valid   = MemRead | MemWrite;
    req_idx     = Address[IDX_W+1:2];
    req_illegal = (Address[1:0] != 2'b00)
                | ((Address >> (IDX_W + 2)) != '0)
                | (MemRead & MemWrite);
  end

  // FSM: accept in IDLE, count down in WAIT, pulse MemReady in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    illegal_d  = illegal_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d     = req_idx;
          wdata_d   = WriteData;
          rd_d      = MemRead;
          wr_d      = MemWrite;
          illegal_d = req_illegal;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Completion: on the edge into RESP commit a legal write or capture read data.
  // With LATENCY=1 that edge is the acceptance edge, so use the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      c_idx     = req_idx;
      c_wdata   = WriteData;
      c_rd      = MemRead;
      c_wr      = MemWrite;
      c_illegal = req_illegal;
    end else begin
      c_idx     = idx_q;
      c_wdata   = wdata_q;
      c_rd      = rd_q;
      c_wr      = wr_q;
      c_illegal = illegal_q;
    end
    mem_we  = enter_resp & c_wr & ~c_illegal;
    rdata_d = rdata_q;
    if (enter_resp && c_rd) begin
      rdata_d = c_illegal ? '0 : mem_q[c_idx];
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      illegal_q <= illegal_d;
      rdata_q   <= rdata_d;
    end
  end

  // Word storage; reset clears every word, so it lives in registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign ReadData  = rdata_q;
  assign MemReady  = (state_q == S_RESP);
  assign Busy      = (state_q != S_IDLE);
  assign AddrError = (state_q == S_RESP) & illegal_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=2 and LATENCY=1).
module tb_mem_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data, read_data;
  logic          mem_ready, busy, addr_error;

  logic          r1_read, r1_write;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          r1_ready, r1_busy, r1_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          ready_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Address(address), .WriteData(write_data), .ReadData(read_data),
    .MemReady(mem_ready), .Busy(busy), .AddrError(addr_error)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .MemRead(r1_read), .MemWrite(r1_write),
    .Address(r1_addr), .WriteData(r1_wdata), .ReadData(r1_rdata),
    .MemReady(r1_ready), .Busy(r1_busy), .AddrError(r1_err)
  );

  // Scoreboard monitor: every MemReady pops one expected response.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: MemReady=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (addr_error !== mon_e.err) begin
          bad++;
          $display("FAIL %s_err: got %b, required %b", mon_e.name, addr_error, mon_e.err);
        end
        total++;
        if (cyc != mon_e.ready_cyc) begin
          bad++;
          $display("FAIL %s_latency: ready at cycle %0d, required %0d", mon_e.name, cyc, mon_e.ready_cyc);
        end
        if (mon_e.chk_data) begin
          total++;
          if (read_data !== mon_e.data) begin
            bad++;
            $display("FAIL %s_data: got %h, required %h", mon_e.name, read_data, mon_e.data);
          end
        end
        $display("txn %s: data=%h err=%b cycle=%0d", mon_e.name, read_data, addr_error, cyc);
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic e, input logic chk,
                          input int rc, input string nm);
    exp_t x;
    x.data = d; x.err = e; x.chk_data = chk; x.ready_cyc = rc; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ee,
                       input logic chk, input string nm);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    push_exp(ed, ee, chk, cyc + LAT, nm);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    wait_drain(nm);
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b1; address = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, required 0", mem_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h, required 0", read_data); end
    total++; if (r1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_l1: got %b, required 0", r1_busy); end
    rst = 1'b1; mem_read = 1'b0;
    issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, "rd_0x10");
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "wr_0x8");
    issue(1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, "rd_0xC");
    issue(1'b1, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "rd_0x8");
  endtask

  task automatic test_errors();
    issue(1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1'b1, "rd_misaligned");
    issue(1'b0, 1'b1, 32'h400, 32'h77777777, 32'h0, 1'b1, 1'b0, "wr_out_of_range");
    issue(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "rd_0x0_after_oor");
    issue(1'b1, 1'b1, 32'h0, 32'h55555555, 32'h0, 1'b1, 1'b0, "rdwr_both");
    issue(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "rd_0x0_after_both");
  endtask

  task automatic test_busy_drop();
    issue(1'b0, 1'b1, 32'h4, 32'h0BADCAFE, 32'h0, 1'b0, 1'b0, "wr_0x4");
    @(posedge clk); #1;
    mem_read = 1'b1; address = 32'h4;
    push_exp(32'h0BADCAFE, 1'b0, 1'b1, cyc + LAT, "rd_0x4_busy");
    @(posedge clk); #1;
    mem_read = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_wait: got %b, required 1", busy); end
    mem_write = 1'b1; write_data = 32'h1234;
    @(posedge clk); #1;
    mem_write = 1'b0;
    wait_drain("busy_drop");
    repeat (4) @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h4, 32'h0, 32'h0BADCAFE, 1'b0, 1'b1, "rd_0x4_after_drop");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h0BADCAFE; vals[2] = 32'hDEADBEEF;
    issue(1'b0, 1'b1, 32'h0, vals[0], 32'h0, 1'b0, 1'b0, "wr_0x0");
    @(posedge clk); #1;
    mem_read = 1'b1; address = 32'h0;
    push_exp(vals[0], 1'b0, 1'b1, cyc + LAT, "fetch_0");
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (mem_ready !== 1'b1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      total++;
      if (mem_ready !== 1'b1) begin
        bad++;
        $display("FAIL fetch_%0d_wait: MemReady=%b, required 1", k, mem_ready);
      end
      if (k < 2) begin
        address = 32'(4 * (k + 1));
        push_exp(vals[k+1], 1'b0, 1'b1, cyc + LAT + 1, $sformatf("fetch_%0d", k + 1));
      end else begin
        mem_read = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0;
    wait_drain("fetch");
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    mem_write = 1'b1; address = 32'h20; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b, required 1", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b, required 0", mem_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: busy=%b, required 0", busy); end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, "rd_0x20_after_rst");
  endtask

  task automatic test_latency1();
    @(posedge clk); #1;
    r1_write = 1'b1; r1_addr = 32'h30; r1_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    r1_write = 1'b0;
    total++; if (r1_ready !== 1'b1) begin bad++; $display("FAIL l1_wr_ready: got %b, required 1", r1_ready); end
    total++; if (r1_err !== 1'b0) begin bad++; $display("FAIL l1_wr_err: got %b, required 0", r1_err); end
    $display("txn l1_wr_0x30: ready=%b err=%b", r1_ready, r1_err);
    @(posedge clk); #1;
    total++; if (r1_ready !== 1'b0) begin bad++; $display("FAIL l1_pulse_width: got %b, required 0", r1_ready); end
    r1_read = 1'b1; r1_addr = 32'h30;
    @(posedge clk); #1;
    r1_read = 1'b0;
    total++; if (r1_ready !== 1'b1) begin bad++; $display("FAIL l1_rd_ready: got %b, required 1", r1_ready); end
    total++; if (r1_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL l1_rd_data: got %h, required a5a5a5a5", r1_rdata); end
    $display("txn l1_rd_0x30: data=%h ready=%b", r1_rdata, r1_ready);
    @(posedge clk); #1;
    r1_read = 1'b1; r1_addr = 32'h31;
    @(posedge clk); #1;
    r1_read = 1'b0;
    total++; if (r1_ready !== 1'b1) begin bad++; $display("FAIL l1_bad_ready: got %b, required 1", r1_ready); end
    total++; if (r1_err !== 1'b1) begin bad++; $display("FAIL l1_bad_err: got %b, required 1", r1_err); end
    total++; if (r1_rdata !== 32'h0) begin bad++; $display("FAIL l1_bad_data: got %h, required 0", r1_rdata); end
    $display("txn l1_rd_0x31: data=%h err=%b", r1_rdata, r1_err);
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    r1_read = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    test_reset();
    test_write_read();
    test_errors();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_write();
    test_latency1();
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath's memory interface.
- The control unit issues MemRead/MemWrite with an address; this block accepts one request at a time and models a fixed access latency.
- It completes each request with a one-cycle MemReady pulse, returning read data or an error flag.
- It contains the word storage, so the fetch sequence (PC → address, instruction → IR) can run against it directly.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of words stored; power of two.
- LATENCY, 2, cycles from request acceptance to MemReady; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- MemRead  input  1  read request from control.
- MemWrite  input  1  write request from control.
- Address  input  ADDR_W  byte address of the access.
- WriteData  input  DATA_W  data for writes.
- ReadData  output  DATA_W  read result; valid when MemReady=1.
- MemReady  output  1  one-cycle completion pulse.
- Busy  output  1  high while a request is in flight; new requests are ignored.
- AddrError  output  1  high together with MemReady when the completed request was illegal.

Behaviour:
- **Reset.** rst=0 at an edge forces:
  - state IDLE, latency counter 0;
  - ReadData=0, MemReady=0, Busy=0, AddrError=0;
  - all DEPTH words cleared to 0.
  - Reset mid-operation aborts the request: no write commits and no MemReady is produced.
- **Word index.** index = Address[log2(DEPTH)+1 : 2].
- **Illegal request**, any of:
  - Address[1:0] != 0;
  - any Address bit above log2(DEPTH)+1 is set;
  - MemRead and MemWrite both high at acceptance.
- **State IDLE.** Busy=0.
  - If MemRead or MemWrite is high at an edge, the request is accepted.
  - On acceptance, latch Address, WriteData, op and the illegal flag.
  - Next state is RESP if LATENCY=1, otherwise WAIT with counter = LATENCY-1.
- **State WAIT.** Busy=1. The counter decrements each edge; at count 1 the next state is RESP. Request inputs are ignored.
- **State RESP.** Busy=1, MemReady=1 for exactly this cycle, AddrError = latched illegal flag. Next state is IDLE unconditionally.
- **Latency.** Request sampled at edge T; MemReady is high in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- **Read completion:**
  - Legal read: ReadData = mem[index], driven in the RESP cycle.
  - Illegal read: ReadData = 0.
  - ReadData holds its value after RESP until the next read completes; writes do not change it.
- **Write completion:**
  - Legal write: mem[index] is written with the latched WriteData at the edge entering RESP. A read accepted after that MemReady returns the new value.
  - Illegal write: no memory change.
- **Held request.** Control must drop MemRead/MemWrite during the RESP cycle. If a request is still high in the first IDLE cycle after RESP, it is accepted as a new request; this is legal and tested.
- **Ignored requests.** Requests asserted while Busy=1 are dropped, not queued.
- **Back-to-back.** The minimum spacing between acceptances is LATENCY+1 cycles.

Test Plan:
1. **Reset.** Hold rst=0 for 2 edges with MemRead=1 → MemReady=0, Busy=0, ReadData=0. Release and read addr 0x10 → ReadData=0x00000000 with MemReady exactly 2 cycles after acceptance (LATENCY=2).
2. **Write then read.** MemWrite=1, Address=0x0000_0008, WriteData=0xDEADBEEF, then MemRead at 0x8 → second MemReady shows ReadData=0xDEADBEEF, AddrError=0. Addr 0xC still reads 0.
3. **Errors.**
   - Read at 0x0000_0006 (misaligned) → MemReady with AddrError=1, ReadData=0.
   - Write at 0x0000_0400 (out of range, DEPTH=256) → AddrError=1, and reading 0x0 afterwards is unchanged.
   - MemRead=MemWrite=1 → AddrError=1, no write.
4. **Busy drop.** Accept a read at 0x4. Pulse MemWrite at 0x4 with 0x1234 during WAIT → ignored; only one MemReady occurs, and a later read of 0x4 returns its prior value.
5. **Held request / fetch loop.** Keep MemRead=1 continuously with Address stepping 0x0, 0x4, 0x8 after each MemReady → MemReady pulses every 3 cycles (LATENCY=2), data returned in order.
6. **Reset mid-write and LATENCY=1.**
   - Accept a write of 0xCAFEF00D to 0x20, assert rst=0 in the WAIT cycle → no MemReady; reading 0x20 afterwards returns 0.
   - Rebuild with LATENCY=1 → MemReady in the cycle immediately after acceptance.
